// File: rtl/uart_tx_flow.sv
// uart_tx_flow: 8N1 byte-serial UART transmitter with optional CTS gating.
// Each accepted byte is sent as one start bit, eight data bits (LSB first)
// and one stop bit. uart_data_sent pulses on the last stop-bit cycle so the
// producer can present its next byte. All outputs come straight from flops.
module uart_tx_flow #(
  parameter int CLKS_PER_BIT = 868,
  parameter int USE_CTS      = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] uart_data,
  input  logic       send_uart_data,
  input  logic       laptop_can_receive,
  output logic       uart_tx,
  output logic       uart_data_sent,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_cnt_nxt;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_nxt;
  logic [7:0]       shift;
  logic [7:0]       shift_nxt;
  logic             accept;
  logic             baud_last;
  logic             tx_nxt;
  logic             sent_nxt;
  logic             busy_nxt;

  // With CTS disabled the host handshake is ignored entirely.
  assign accept    = send_uart_data && (laptop_can_receive || (USE_CTS == 0));
  assign baud_last = (baud_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: every non-idle state lasts whole bit periods.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_START;
      S_START: if (baud_last) state_nxt = S_DATA;
      S_DATA:  if (baud_last && (bit_idx == 3'd7)) state_nxt = S_STOP;
      S_STOP:  if (baud_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the baud counter, bit index and shift register.
  always_comb begin
    baud_cnt_nxt = baud_cnt;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift;
    case (state)
      S_IDLE: begin
        baud_cnt_nxt = '0;
        bit_idx_nxt  = '0;
        if (accept) shift_nxt = uart_data;
      end
      S_START: begin
        baud_cnt_nxt = baud_last ? '0 : baud_cnt + CNT_W'(1);
      end
      S_DATA: begin
        baud_cnt_nxt = baud_last ? '0 : baud_cnt + CNT_W'(1);
        if (baud_last) begin
          // bit_idx wraps 7 -> 0 naturally as the frame leaves DATA.
          bit_idx_nxt = bit_idx + 3'd1;
          shift_nxt   = {1'b0, shift[7:1]};
        end
      end
      S_STOP: begin
        baud_cnt_nxt = baud_last ? '0 : baud_cnt + CNT_W'(1);
      end
      default: begin
        baud_cnt_nxt = '0;
        bit_idx_nxt  = '0;
      end
    endcase
  end

  // Baud counter and bit index registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
    end
  end

  // Shift register holds payload only; its content is irrelevant outside a frame.
  always_ff @(posedge clock) begin
    shift <= shift_nxt;
  end

  // Output decode from next-cycle state so the line is driven by a flop.
  always_comb begin
    tx_nxt   = 1'b1;
    sent_nxt = 1'b0;
    busy_nxt = (state_nxt != S_IDLE);
    case (state_nxt)
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = shift_nxt[0];
      S_STOP:  sent_nxt = (baud_cnt_nxt == CNT_LAST);
      default: tx_nxt = 1'b1;
    endcase
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      uart_tx        <= 1'b1;
      uart_data_sent <= 1'b0;
      busy           <= 1'b0;
    end else begin
      uart_tx        <= tx_nxt;
      uart_data_sent <= sent_nxt;
      busy           <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_flow.sv
// Bench for uart_tx_flow: cycle-exact waveform checks plus a serial receiver
// model that decodes each line and compares bytes against a scoreboard.
module tb_uart_tx_flow;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic [7:0] data_a;
  logic       send_a;
  logic       cts_a;
  logic       tx_a;
  logic       sent_a;
  logic       busy_a;
  logic [7:0] data_b;
  logic       send_b;
  logic       cts_b;
  logic       tx_b;
  logic       sent_b;
  logic       busy_b;

  int    n_checks = 0;
  int    n_fails  = 0;
  string phase    = "init";

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  uart_tx_flow #(.CLKS_PER_BIT(CPB), .USE_CTS(1)) dut_a (
    .clock              (clk),
    .reset              (rst),
    .uart_data          (data_a),
    .send_uart_data     (send_a),
    .laptop_can_receive (cts_a),
    .uart_tx            (tx_a),
    .uart_data_sent     (sent_a),
    .busy               (busy_a)
  );

  uart_tx_flow #(.CLKS_PER_BIT(CPB), .USE_CTS(0)) dut_b (
    .clock              (clk),
    .reset              (rst),
    .uart_data          (data_b),
    .send_uart_data     (send_b),
    .laptop_can_receive (cts_b),
    .uart_tx            (tx_b),
    .uart_data_sent     (sent_b),
    .busy               (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Current cycle is the accept cycle. Checks all 40 frame cycles and the one after.
  // mode 0: drop request at uart_data_sent; 1: keep request, present nd;
  // mode 2: perturb cts/data/request during data bit 3.
  task automatic run_frame(input bit sel, input logic [7:0] d, input int mode,
                           input logic [7:0] nd);
    logic exp_tx;
    if (sel) begin
      send_b = 1'b1;
      data_b = d;
      exp_q1.push_back(d);
    end else begin
      send_a = 1'b1;
      data_a = d;
      cts_a  = 1'b1;
      exp_q0.push_back(d);
    end
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i <= 4)       exp_tx = 1'b0;
      else if (i <= 36) exp_tx = d[(i - 5) / 4];
      else              exp_tx = 1'b1;
      check($sformatf("tx[%0d]", i),   sel ? tx_b   : tx_a,   exp_tx);
      check($sformatf("sent[%0d]", i), sel ? sent_b : sent_a, (i == 40));
      check($sformatf("busy[%0d]", i), sel ? busy_b : busy_a, 1'b1);
      if (mode == 2 && i == 17) begin
        cts_a  = 1'b0;
        data_a = 8'h00;
        send_a = 1'b0;
      end
      if (i == 40) begin
        if (mode == 1) begin
          if (sel) data_b = nd; else data_a = nd;
        end else begin
          if (sel) send_b = 1'b0; else send_a = 1'b0;
        end
      end
    end
    tick();
    check("tx_after",   sel ? tx_b   : tx_a,   1'b1);
    check("sent_after", sel ? sent_b : sent_a, 1'b0);
    check("busy_after", sel ? busy_b : busy_a, 1'b0);
  endtask

  // Serial receiver model: samples each bit at its centre and scores the byte.
  initial begin
    bit         rx_act[2];
    int         rx_cnt[2];
    logic       rx_prev[2];
    logic [7:0] rx_sh[2];
    logic       line;
    logic [7:0] expb;
    int         k;
    for (int d = 0; d < 2; d++) begin
      rx_act[d] = 1'b0; rx_cnt[d] = 0; rx_prev[d] = 1'b1; rx_sh[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        line = (d == 1) ? tx_b : tx_a;
        if (rst) begin
          rx_act[d] = 1'b0;
          line      = 1'b1;
        end else if (!rx_act[d]) begin
          if (rx_prev[d] === 1'b1 && line === 1'b0) begin
            rx_act[d] = 1'b1;
            rx_cnt[d] = 0;
          end
        end else begin
          rx_cnt[d]++;
          if (rx_cnt[d] % CPB == CPB / 2) begin
            k = rx_cnt[d] / CPB;
            if (k == 0) begin
              check("rx_start", line, 1'b0);
            end else if (k <= 8) begin
              rx_sh[d][k-1] = line;
            end else begin
              check("rx_stop", line, 1'b1);
              rx_act[d] = 1'b0;
              if (d == 0) begin
                check("rx_queue_a", exp_q0.size() != 0, 1'b1);
                if (exp_q0.size() != 0) begin
                  expb = exp_q0.pop_front();
                  check("rx_byte_a", rx_sh[d], expb);
                end
              end else begin
                check("rx_queue_b", exp_q1.size() != 0, 1'b1);
                if (exp_q1.size() != 0) begin
                  expb = exp_q1.pop_front();
                  check("rx_byte_b", rx_sh[d], expb);
                end
              end
            end
          end
        end
        rx_prev[d] = line;
      end
    end
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    data_a = '0; send_a = 1'b0; cts_a = 1'b0;
    data_b = '0; send_b = 1'b0; cts_b = 1'b0;
    tick();
    tick();
    phase = "reset";
    check("tx_a",   tx_a,   1'b1);
    check("sent_a", sent_a, 1'b0);
    check("busy_a", busy_a, 1'b0);
    check("tx_b",   tx_b,   1'b1);
    check("busy_b", busy_b, 1'b0);
    rst = 1'b0;
    tick();

    phase = "basic_a5";
    run_frame(1'b0, 8'hA5, 0, 8'h00);
    tick();

    phase = "cts_hold";
    cts_a  = 1'b0;
    send_a = 1'b1;
    data_a = 8'h3C;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("tx_idle",   tx_a,   1'b1);
      check("busy_idle", busy_a, 1'b0);
      check("sent_idle", sent_a, 1'b0);
    end
    run_frame(1'b0, 8'h3C, 0, 8'h00);
    tick();

    phase = "b2b_01";
    run_frame(1'b0, 8'h01, 1, 8'hFF);
    phase = "b2b_ff";
    run_frame(1'b0, 8'hFF, 0, 8'h00);
    tick();

    phase = "perturb";
    run_frame(1'b0, 8'hC3, 2, 8'h00);
    cts_a = 1'b1;
    tick();

    phase = "reset_mid";
    send_a = 1'b1;
    data_a = 8'h96;
    for (int i = 1; i <= 15; i++) tick();
    check("tx_bit2", tx_a, 1'b1);
    rst    = 1'b1;
    send_a = 1'b0;
    tick();
    check("tx_rst",   tx_a,   1'b1);
    check("busy_rst", busy_a, 1'b0);
    check("sent_rst", sent_a, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      check("sent_none", sent_a, 1'b0);
      check("tx_quiet",  tx_a,   1'b1);
    end
    phase = "after_reset";
    run_frame(1'b0, 8'h69, 0, 8'h00);
    tick();

    phase = "no_cts_5a";
    cts_b = 1'b0;
    run_frame(1'b1, 8'h5A, 0, 8'h00);
    for (int i = 0; i < 4; i++) tick();

    phase = "final";
    check("queue_a_empty", exp_q0.size(), 0);
    check("queue_b_empty", exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
